// File: rtl/lstm_cell_update_if.sv
// Handshake and vector bus between the four LSTM gate blocks and the cell-state update.
// The master drives the gate vectors and the start/clear strobes. The slave returns
// status plus the h and c vectors.
interface lstm_cell_update_if #(
    parameter int HIDDEN_SZ      = 16,
    parameter int QN             = 6,
    parameter int QM             = 11,
    parameter int BITWIDTH       = QN + QM + 1,
    parameter int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ
);
    logic                      beginCalc;
    logic                      clearState;
    logic [LAYER_BITWIDTH-1:0] inputGate;
    logic [LAYER_BITWIDTH-1:0] forgetGate;
    logic [LAYER_BITWIDTH-1:0] outputGate;
    logic [LAYER_BITWIDTH-1:0] candidate;
    logic                      busy;
    logic                      dataReady;
    logic [LAYER_BITWIDTH-1:0] hiddenOut;
    logic [LAYER_BITWIDTH-1:0] cellOut;

    modport master (
        output beginCalc, clearState, inputGate, forgetGate, outputGate, candidate,
        input  busy, dataReady, hiddenOut, cellOut
    );

    modport slave (
        input  beginCalc, clearState, inputGate, forgetGate, outputGate, candidate,
        output busy, dataReady, hiddenOut, cellOut
    );
endinterface

// File: rtl/lstm_cell_update.sv
// Element-wise LSTM state update: c = f*c + i*g, h = o*tanh(c).
// One shared signed multiplier serves all elements. Each element takes four cycles.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting; clearState zeroes c, beginCalc latches gate vectors
//   S_FC   | pfc = sat(f*c)
//   S_IG   | c_new = sat(pfc + sat(i*g)), written back into cell storage
//   S_TANH | t = tanh_pwl(c_new)
//   S_OH   | h = sat(o*t); advance element or finish
//   DONE   | dataReady pulse, back to IDLE
module lstm_cell_update #(
    parameter int HIDDEN_SZ      = 16,
    parameter int QN             = 6,
    parameter int QM             = 11,
    parameter int BITWIDTH       = QN + QM + 1,
    parameter int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ
) (
    input  logic              clock,
    input  logic              reset,
    lstm_cell_update_if.slave bus
);
    localparam int BW    = BITWIDTH;
    localparam int PW    = 2 * BITWIDTH;
    localparam int IDX_W = (HIDDEN_SZ > 1) ? $clog2(HIDDEN_SZ) : 1;

    localparam logic signed [PW-1:0] SAT_MAX = {{(BW+1){1'b0}}, {(BW-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(BW+1){1'b1}}, {(BW-1){1'b0}}};
    localparam logic signed [BW-1:0] EL_MIN  = {1'b1, {(BW-1){1'b0}}};
    localparam logic        [BW-1:0] EL_MAXU = {1'b0, {(BW-1){1'b1}}};

    // tanh breakpoints and offsets in Q(QM)
    localparam logic [BW-1:0] T_HALF  = BW'(1) << (QM - 1);
    localparam logic [BW-1:0] T_1P5   = BW'(3) << (QM - 1);
    localparam logic [BW-1:0] T_3     = BW'(3) << QM;
    localparam logic [BW-1:0] C_5_16  = BW'(5) << (QM - 4);
    localparam logic [BW-1:0] C_25_32 = BW'(25) << (QM - 5);
    localparam logic [BW-1:0] C_ONE   = BW'(1) << QM;

    typedef enum logic [2:0] {IDLE, S_FC, S_IG, S_TANH, S_OH, DONE} state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   busy_q;
    logic                   ready_q;
    logic signed [BW-1:0]   pfc_q;
    logic signed [BW-1:0]   cnew_q;
    logic signed [BW-1:0]   t_q;
    logic signed [BW-1:0]   i_q    [HIDDEN_SZ];
    logic signed [BW-1:0]   f_q    [HIDDEN_SZ];
    logic signed [BW-1:0]   o_q    [HIDDEN_SZ];
    logic signed [BW-1:0]   g_q    [HIDDEN_SZ];
    logic signed [BW-1:0]   cell_q [HIDDEN_SZ];
    logic signed [BW-1:0]   hid_q  [HIDDEN_SZ];

    logic signed [BW-1:0]   mul_a;
    logic signed [BW-1:0]   mul_b;
    logic signed [PW-1:0]   mul_a_w;
    logic signed [PW-1:0]   mul_b_w;
    logic signed [PW-1:0]   prod;
    logic signed [BW-1:0]   msat_d;
    logic signed [BW:0]     sum_d;
    logic signed [PW-1:0]   sum_w;
    logic signed [BW-1:0]   cnew_d;

    function automatic logic signed [BW-1:0] sat(input logic signed [PW-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[BW-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[BW-1:0];
        else
            return v[BW-1:0];
    endfunction

    // Odd-symmetric piecewise-linear tanh built from shifts and adds only
    function automatic logic signed [BW-1:0] tanh_pwl(input logic signed [BW-1:0] x);
        logic [BW-1:0] a;
        logic [BW-1:0] y;
        if (x == EL_MIN)
            a = EL_MAXU;
        else if (x[BW-1])
            a = $unsigned(-x);
        else
            a = $unsigned(x);
        if (a < T_HALF)
            y = a;
        else if (a < T_1P5)
            y = (a >> 2) + (a >> 3) + C_5_16;
        else if (a < T_3)
            y = (a >> 4) + C_25_32;
        else
            y = C_ONE;
        return x[BW-1] ? $signed(-y) : $signed(y);
    endfunction

    // Shared multiplier: operand mux by state, full-width product, shift, saturate
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_FC: begin
                mul_a = f_q[idx_q];
                mul_b = cell_q[idx_q];
            end
            S_IG: begin
                mul_a = i_q[idx_q];
                mul_b = g_q[idx_q];
            end
            S_OH: begin
                mul_a = o_q[idx_q];
                mul_b = t_q;
            end
            default: ;
        endcase
        mul_a_w = mul_a;
        mul_b_w = mul_b;
        prod    = mul_a_w * mul_b_w;
        msat_d  = sat(prod >>> QM);
        sum_d   = {pfc_q[BW-1], pfc_q} + {msat_d[BW-1], msat_d};
        sum_w   = sum_d;
        cnew_d  = sat(sum_w);
    end

    // Sequencer and all datapath/output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            pfc_q   <= '0;
            cnew_q  <= '0;
            t_q     <= '0;
            for (int k = 0; k < HIDDEN_SZ; k++) begin
                i_q[k]    <= '0;
                f_q[k]    <= '0;
                o_q[k]    <= '0;
                g_q[k]    <= '0;
                cell_q[k] <= '0;
                hid_q[k]  <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.clearState) begin
                        for (int k = 0; k < HIDDEN_SZ; k++)
                            cell_q[k] <= '0;
                    end
                    if (bus.beginCalc) begin
                        for (int k = 0; k < HIDDEN_SZ; k++) begin
                            i_q[k] <= bus.inputGate[k*BW +: BW];
                            f_q[k] <= bus.forgetGate[k*BW +: BW];
                            o_q[k] <= bus.outputGate[k*BW +: BW];
                            g_q[k] <= bus.candidate[k*BW +: BW];
                        end
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_FC;
                    end
                end
                S_FC: begin
                    pfc_q   <= msat_d;
                    state_q <= S_IG;
                end
                S_IG: begin
                    cnew_q         <= cnew_d;
                    cell_q[idx_q]  <= cnew_d;
                    state_q        <= S_TANH;
                end
                S_TANH: begin
                    t_q     <= tanh_pwl(cnew_q);
                    state_q <= S_OH;
                end
                S_OH: begin
                    hid_q[idx_q] <= msat_d;
                    if (idx_q == IDX_W'(HIDDEN_SZ - 1)) begin
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= S_FC;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.dataReady = ready_q;

    for (genvar k = 0; k < HIDDEN_SZ; k++) begin : g_pack
        assign bus.hiddenOut[k*BW +: BW] = hid_q[k];
        assign bus.cellOut[k*BW +: BW]   = cell_q[k];
    end
endmodule

// File: tb/tb_lstm_cell_update.sv
// Directed bench for lstm_cell_update (HIDDEN_SZ=16, QM=11).
module tb_lstm_cell_update;
    localparam int HS = 16;
    localparam int BW = 18;
    localparam int LW = BW * HS;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    lstm_cell_update_if #(.HIDDEN_SZ(HS), .QN(6), .QM(11)) bus ();

    lstm_cell_update #(.HIDDEN_SZ(HS), .QN(6), .QM(11)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic longint elem(input logic [LW-1:0] v, input int k);
        return longint'($signed(v[k*BW +: BW]));
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [LW-1:0] v, input longint exp);
        for (int k = 0; k < HS; k++)
            check($sformatf("%s[%0d]", tag, k), elem(v, k), exp);
    endtask

    task automatic set_all(input longint f, input longint i, input longint g, input longint o);
        for (int k = 0; k < HS; k++) begin
            bus.forgetGate[k*BW +: BW] = BW'(f);
            bus.inputGate[k*BW +: BW]  = BW'(i);
            bus.candidate[k*BW +: BW]  = BW'(g);
            bus.outputGate[k*BW +: BW] = BW'(o);
        end
    endtask

    // Drive a one-cycle start; returns #1 after the start edge
    task automatic start(input logic clr);
        bus.beginCalc  = 1'b1;
        bus.clearState = clr;
        @(posedge clock);
        #1;
        bus.beginCalc  = 1'b0;
        bus.clearState = 1'b0;
    endtask

    // Follow one run to completion; optionally pokes beginCalc/clearState/gates mid-run
    task automatic run_op(input string tag, input int poke_at);
        int n;
        int rdy_at;
        int rdy_cnt;
        int busy_cnt;
        n = 0; rdy_at = -1; rdy_cnt = 0; busy_cnt = 0;
        while (bus.busy && n < 300) begin
            busy_cnt++;
            if (bus.dataReady) begin
                rdy_cnt++;
                rdy_at = n;
            end
            if (n == poke_at) begin
                bus.beginCalc  = 1'b1;
                bus.clearState = 1'b1;
                set_all(7, 7, 7, 7);
            end else begin
                bus.beginCalc  = 1'b0;
                bus.clearState = 1'b0;
            end
            @(posedge clock);
            #1;
            n++;
        end
        bus.beginCalc  = 1'b0;
        bus.clearState = 1'b0;
        check({tag, " ready_cycle"}, rdy_at, 64);
        check({tag, " ready_count"}, rdy_cnt, 1);
        check({tag, " busy_cycles"}, busy_cnt, 65);
        check({tag, " ready_after"}, longint'(bus.dataReady), 0);
    endtask

    initial begin
        int rdy_seen;
        bus.beginCalc  = 1'b0;
        bus.clearState = 1'b0;
        set_all(0, 0, 0, 0);

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst busy", longint'(bus.busy), 0);
        check("rst ready", longint'(bus.dataReady), 0);
        check_vec("rst c", bus.cellOut, 0);
        check_vec("rst h", bus.hiddenOut, 0);

        // c = 0 + 0.5*0.5 = 0.25, tanh identity
        set_all(2048, 1024, 1024, 2048);
        start(1'b1);
        run_op("run1", -1);
        check_vec("run1 c", bus.cellOut, 512);
        check_vec("run1 h", bus.hiddenOut, 512);

        // accumulate without clear: 0.5 (segment edge), then 0.75
        start(1'b0);
        run_op("run2", -1);
        check_vec("run2 c", bus.cellOut, 1024);
        check_vec("run2 h", bus.hiddenOut, 1024);
        start(1'b0);
        run_op("run3", -1);
        check_vec("run3 c", bus.cellOut, 1536);
        check_vec("run3 h", bus.hiddenOut, 1216);

        // negative middle segment: tanh(-1.0) = -0.6875, h = 0.5*that
        set_all(0, 2048, -2048, 1024);
        start(1'b1);
        run_op("neg", -1);
        check_vec("neg c", bus.cellOut, -2048);
        check_vec("neg h", bus.hiddenOut, -704);

        // upper segment: c = 2.0 -> 2.0/16 + 0.78125 = 0.90625
        set_all(0, 2048, 4096, 2048);
        start(1'b1);
        run_op("seg3", -1);
        check_vec("seg3 c", bus.cellOut, 4096);
        check_vec("seg3 h", bus.hiddenOut, 1856);

        // product saturates high, tanh clamps to 1.0
        set_all(2048, 129024, 129024, 2048);
        start(1'b1);
        run_op("sath", -1);
        check_vec("sath c", bus.cellOut, 131071);
        check_vec("sath h", bus.hiddenOut, 2048);

        // negative product saturates at -131072, so 131071 + (-131072) = -1
        set_all(2048, -129024, 129024, 2048);
        start(1'b0);
        run_op("satmix", -1);
        check_vec("satmix c", bus.cellOut, -1);
        check_vec("satmix h", bus.hiddenOut, -1);

        // clearState alone zeroes c and leaves h untouched
        bus.clearState = 1'b1;
        @(posedge clock);
        #1;
        bus.clearState = 1'b0;
        check("clr busy", longint'(bus.busy), 0);
        check_vec("clr c", bus.cellOut, 0);
        check_vec("clr h", bus.hiddenOut, -1);

        // most negative c: tanh magnitude taken as max positive -> -1.0
        set_all(0, -129024, 129024, 2048);
        start(1'b1);
        run_op("satl", -1);
        check_vec("satl c", bus.cellOut, -131072);
        check_vec("satl h", bus.hiddenOut, -2048);

        // per-element indexing; start/clear and gate changes mid-run must be ignored
        set_all(0, 2048, 0, 2048);
        for (int k = 0; k < HS; k++)
            bus.candidate[k*BW +: BW] = BW'(k * 64);
        start(1'b1);
        run_op("idx", 5);
        for (int k = 0; k < HS; k++) begin
            check($sformatf("idx c[%0d]", k), elem(bus.cellOut, k), longint'(k * 64));
            check($sformatf("idx h[%0d]", k), elem(bus.hiddenOut, k), longint'(k * 64));
        end

        // reset mid-run aborts with outputs cleared and no dataReady
        set_all(2048, 1024, 1024, 2048);
        start(1'b0);
        repeat (19) @(posedge clock);
        #1;
        check("midrun busy", longint'(bus.busy), 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort busy", longint'(bus.busy), 0);
        check("abort ready", longint'(bus.dataReady), 0);
        check_vec("abort c", bus.cellOut, 0);
        check_vec("abort h", bus.hiddenOut, 0);
        rdy_seen = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clock);
            #1;
            if (bus.dataReady || bus.busy) rdy_seen++;
        end
        check("abort quiet", rdy_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
